// File: rtl/config_pkg.sv
// Shared matrix-unit configuration: DDR bus types, requester count and the
// DDR port arbiter state encoding.
package config_pkg;

  localparam int DdrAddrWidth = 32;
  localparam int DdrDataWidth = 32;

  typedef logic [DdrAddrWidth-1:0] ddr_address_t;
  typedef logic [DdrDataWidth-1:0] ddr_data_t;

  // Requester 0 = vector load/store, 1 = ternary matmul stream.
  localparam int DdrRequesters = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    HELD
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: one-hot grant for the first set request
// at or after the pointer, wrapping modulo the requester count.
module rr_priority_picker #(
  parameter  int NumReq = 2,
  localparam int PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic              valid_o
);

  int            slot;
  logic [PtrW-1:0] idx;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    slot    = 0;
    idx     = '0;
    for (int i = 0; i < NumReq; i++) begin
      slot = int'(ptr_i) + i;
      if (slot >= NumReq) slot = slot - NumReq;
      idx = PtrW'(slot);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing the single DDR port between requesters at
// transaction granularity, with an optional bounded lock for streaming ports.
module ddr_port_arbiter
  import config_pkg::*;
#(
  parameter int NumRequesters = DdrRequesters,
  parameter int MaxLockBeats  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic         [NumRequesters-1:0] req_i,
  input  logic         [NumRequesters-1:0] req_we_i,
  input  ddr_address_t [NumRequesters-1:0] req_addr_i,
  input  ddr_data_t    [NumRequesters-1:0] req_w_data_i,
  input  logic         [NumRequesters-1:0] lock_i,
  output logic         [NumRequesters-1:0] gnt_o,
  output logic         [NumRequesters-1:0] done_o,
  output ddr_data_t                        r_data_o,
  output ddr_address_t                     ddr_address_o,
  output logic                             ddr_w_en_o,
  output ddr_data_t                        ddr_w_data_o,
  input  logic                             ddr_w_done_i,
  output logic                             ddr_r_en_o,
  input  ddr_data_t                        ddr_r_data_i,
  input  logic                             ddr_r_valid_i
);

  localparam int PtrW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int CntW = (MaxLockBeats > 2) ? $clog2(MaxLockBeats) : 1;
  localparam logic [CntW-1:0] LockLimit = CntW'(MaxLockBeats - 1);

  arb_state_e               state_q, state_d;
  logic [NumRequesters-1:0] gnt_q, gnt_d;
  logic [PtrW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]          lock_cnt_q, lock_cnt_d;

  logic [NumRequesters-1:0] pick_gnt;
  logic                     pick_valid;

  logic                     g_we, g_req, g_lock;
  ddr_address_t             g_addr;
  ddr_data_t                g_wdata;
  logic [PtrW-1:0]          g_idx, next_ptr;
  logic                     others_pending, completion, do_release;

  rr_priority_picker #(
    .NumReq (NumRequesters)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  // Granted requester's view; all fields read as zero while nothing is granted.
  always_comb begin
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    g_idx   = '0;
    for (int k = 0; k < NumRequesters; k++) begin
      if (gnt_q[k]) begin
        g_we    = req_we_i[k];
        g_addr  = req_addr_i[k];
        g_wdata = req_w_data_i[k];
        g_idx   = PtrW'(k);
      end
    end
  end

  assign g_req          = |(req_i & gnt_q);
  assign g_lock         = |(lock_i & gnt_q);
  assign others_pending = |(req_i & ~gnt_q);
  assign completion     = g_we ? ddr_w_done_i : ddr_r_valid_i;
  assign next_ptr       = (g_idx == PtrW'(NumRequesters - 1)) ? '0 : g_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    do_release = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (completion) begin
          if ((g_lock && (lock_cnt_q < LockLimit)) || !others_pending) begin
            state_d = HELD;
            if (lock_cnt_q != LockLimit) lock_cnt_d = lock_cnt_q + 1'b1;
          end else begin
            do_release = 1'b1;
          end
        end
      end
      HELD: begin
        // A follow-on request wins over the fairness bound; the bound only
        // cuts off a locked owner that is idling while others wait.
        if (g_req) begin
          state_d = ACCESS;
        end else if (!g_lock) begin
          do_release = 1'b1;
        end else if (others_pending && (lock_cnt_q >= LockLimit)) begin
          do_release = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    if (do_release) begin
      state_d    = IDLE;
      gnt_d      = '0;
      rr_ptr_d   = next_ptr;
      lock_cnt_d = '0;
    end
  end

  always_comb begin
    gnt_o         = gnt_q;
    done_o        = ((state_q == ACCESS) && completion) ? gnt_q : '0;
    ddr_w_en_o    = (state_q == ACCESS) && g_we;
    ddr_r_en_o    = (state_q == ACCESS) && !g_we;
    ddr_address_o = g_addr;
    ddr_w_data_o  = g_wdata;
    r_data_o      = ddr_r_data_i;
  end

  req_held_during_access : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (state_q == ACCESS) |-> g_req
  ) else $error("granted requester dropped req_i during ACCESS");

endmodule
